// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS front end: reset/fetch window constants,
// the fetch-state encoding and the fetch address legality check.
package mips_pkg;

  localparam logic [31:0] RESET_PC = 32'h0000_3000;
  localparam logic [31:0] IM_BASE  = 32'h0000_3000;
  localparam logic [31:0] IM_TOP   = 32'h0000_6FFC;

  localparam logic [31:0] NOP = 32'h0000_0000;

  typedef enum logic [1:0] {
    ISSUE = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2
  } fetch_state_t;

  // A fetch address is illegal when misaligned or outside [base, top].
  function automatic logic fetch_addr_bad(
    input logic [31:0] addr,
    input logic [31:0] base,
    input logic [31:0] top
  );
    return (addr[1:0] != 2'b00) || (addr < base) || (addr > top);
  endfunction

endpackage

// File: rtl/fetch_unit_fd_reg.sv
// F/D pipeline register. When enabled it loads either a real instruction or,
// if the incoming slot is empty, a bubble (nop, not valid, no exception) while
// still tracking the PC so downstream next-PC logic sees a sane value.
module fd_reg
  import mips_pkg::*;
#(
  parameter logic [31:0] PC_INIT = RESET_PC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_en,
  input  logic        i_valid,
  input  logic [31:0] i_pc,
  input  logic [31:0] i_instr,
  input  logic        i_exc,
  output logic [31:0] o_pc,
  output logic [31:0] o_instr,
  output logic        o_valid,
  output logic        o_exc
);

  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic        r_valid;
  logic        r_exc;

  // Load on enable; an empty slot becomes a bubble rather than stale data.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc    <= PC_INIT;
      r_instr <= NOP;
      r_valid <= 1'b0;
      r_exc   <= 1'b0;
    end else if (i_en) begin
      r_pc    <= i_pc;
      r_instr <= i_valid ? i_instr : NOP;
      r_valid <= i_valid;
      r_exc   <= i_valid & i_exc;
    end
  end

  assign o_pc    = r_pc;
  assign o_instr = r_instr;
  assign o_valid = r_valid;
  assign o_exc   = r_exc;

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: owns F_PC, runs the instruction-memory request/response
// handshake, buffers one returned word across a stall, and feeds the F/D
// register. A bad fetch address never reaches memory; it produces a nop
// carrying the address-error flag instead.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   ISSUE | request F_PC (if legal); a bad F_PC yields its error word now
//   WAIT  | request accepted, waiting for the single response
//   HOLD  | response arrived during a stall, word parked in the buffer
module fetch_unit #(
  parameter logic [31:0] RESET_PC = mips_pkg::RESET_PC,
  parameter logic [31:0] IM_BASE  = mips_pkg::IM_BASE,
  parameter logic [31:0] IM_TOP   = mips_pkg::IM_TOP
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] npc,
  input  logic        stall,
  output logic        im_req_valid,
  output logic [31:0] im_req_addr,
  input  logic        im_req_ready,
  input  logic        im_resp_valid,
  input  logic [31:0] im_resp_data,
  output logic [31:0] F_PC,
  output logic [31:0] D_PC,
  output logic [31:0] D_instr,
  output logic        D_valid,
  output logic        D_exc_adel
);

  import mips_pkg::fetch_state_t, mips_pkg::ISSUE, mips_pkg::WAIT, mips_pkg::HOLD;
  import mips_pkg::NOP, mips_pkg::fetch_addr_bad;

  fetch_state_t r_state;
  fetch_state_t w_state_next;

  logic [31:0] r_f_pc;
  logic [31:0] r_buf;

  logic        w_addr_bad;
  logic        w_req_valid;
  logic        w_word_avail;
  logic [31:0] w_word;
  logic        w_exc;
  logic        w_capture;
  logic        w_advance;

  assign w_addr_bad = fetch_addr_bad(r_f_pc, IM_BASE, IM_TOP);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ISSUE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic. A bad PC stays in ISSUE: its error word is produced
  // directly and F_PC moves on when the stage advances.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ISSUE: begin
        if (!w_addr_bad && im_req_ready) begin
          w_state_next = WAIT;
        end
      end
      WAIT: begin
        if (im_resp_valid) begin
          w_state_next = stall ? HOLD : ISSUE;
        end
      end
      HOLD: begin
        if (!stall) begin
          w_state_next = ISSUE;
        end
      end
      default: w_state_next = ISSUE;
    endcase
  end

  // Output logic: request strobe and which word (if any) is available to D.
  always_comb begin
    w_req_valid  = 1'b0;
    w_word_avail = 1'b0;
    w_word       = NOP;
    w_exc        = 1'b0;
    w_capture    = 1'b0;
    case (r_state)
      ISSUE: begin
        w_req_valid = !w_addr_bad && !reset;
        if (w_addr_bad) begin
          w_word_avail = 1'b1;
          w_exc        = 1'b1;
        end
      end
      WAIT: begin
        if (im_resp_valid) begin
          w_word_avail = 1'b1;
          w_word       = im_resp_data;
          w_capture    = stall;
        end
      end
      HOLD: begin
        w_word_avail = 1'b1;
        w_word       = r_buf;
      end
      default: begin
        w_req_valid = 1'b0;
      end
    endcase
  end

  assign w_advance = w_word_avail && !stall;

  // One-word buffer: keeps a response that lands while the stage is frozen.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_buf <= NOP;
    end else if (w_capture) begin
      r_buf <= im_resp_data;
    end
  end

  // Fetch PC: npc is only sampled when an instruction leaves F, which keeps
  // the delay slot and its branch in D consistent.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_f_pc <= RESET_PC;
    end else if (w_advance) begin
      r_f_pc <= npc;
    end
  end

  fd_reg #(
    .PC_INIT (RESET_PC)
  ) u_fd_reg (
    .clk     (clk),
    .reset   (reset),
    .i_en    (!stall),
    .i_valid (w_word_avail),
    .i_pc    (r_f_pc),
    .i_instr (w_word),
    .i_exc   (w_exc),
    .o_pc    (D_PC),
    .o_instr (D_instr),
    .o_valid (D_valid),
    .o_exc   (D_exc_adel)
  );

  assign im_req_valid = w_req_valid;
  assign im_req_addr  = r_f_pc;
  assign F_PC         = r_f_pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized
// run against a transaction-level model of the fetch stage.
module tb_fetch_unit;

  localparam logic [31:0] T_RESET = 32'h0000_3000;
  localparam logic [31:0] T_BASE  = 32'h0000_3000;
  localparam logic [31:0] T_TOP   = 32'h0000_6FFC;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] npc;
  logic        stall;
  logic        im_req_valid;
  logic [31:0] im_req_addr;
  logic        im_req_ready;
  logic        im_resp_valid;
  logic [31:0] im_resp_data;
  logic [31:0] F_PC;
  logic [31:0] D_PC;
  logic [31:0] D_instr;
  logic        D_valid;
  logic        D_exc_adel;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk           (clk),
    .reset         (reset),
    .npc           (npc),
    .stall         (stall),
    .im_req_valid  (im_req_valid),
    .im_req_addr   (im_req_addr),
    .im_req_ready  (im_req_ready),
    .im_resp_valid (im_resp_valid),
    .im_resp_data  (im_resp_data),
    .F_PC          (F_PC),
    .D_PC          (D_PC),
    .D_instr       (D_instr),
    .D_valid       (D_valid),
    .D_exc_adel    (D_exc_adel)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // instruction memory: one outstanding request, fixed latency per request
  logic        mem_busy = 1'b0;
  logic [31:0] mem_addr = '0;
  int          mem_cnt  = 0;
  int          mem_lat  = 0;
  int          req_count [bit [31:0]];

  // reference model of the fetch stage (program-order, word-availability view)
  logic [31:0] m_fpc, m_dpc, m_instr, m_buf;
  logic        m_valid, m_exc, m_pending, m_buf_valid;

  logic [31:0] redir_from [$];
  logic [31:0] redir_to   [$];

  // values sampled just before the edge of the last tick
  logic        pre_req_dut, pre_req_exp;
  logic [31:0] pre_addr_dut, pre_addr_exp;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5A00_00A5;
  endfunction

  function automatic logic bad_addr(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a < T_BASE) || (a > T_TOP);
  endfunction

  function automatic int get_count(input logic [31:0] a);
    return req_count.exists(a) ? req_count[a] : 0;
  endfunction

  task automatic model_reset();
    m_fpc = T_RESET; m_dpc = T_RESET; m_instr = '0; m_buf = '0;
    m_valid = 1'b0; m_exc = 1'b0; m_pending = 1'b0; m_buf_valid = 1'b0;
  endtask

  task automatic drive_npc();
    npc = m_fpc + 32'd4;
    foreach (redir_from[i]) if (redir_from[i] == m_fpc) npc = redir_to[i];
  endtask

  // One clock: sample pre-edge, step model and memory, drive next inputs.
  task automatic tick();
    logic        hs, resp_seen, avail, exc, bad, resp_s, stall_s, reset_s, ready_s;
    logic [31:0] word, npc_s, rdata_s;
    #2;
    bad          = bad_addr(m_fpc);
    pre_req_dut  = im_req_valid;
    pre_addr_dut = im_req_addr;
    pre_req_exp  = !reset && !m_pending && !m_buf_valid && !bad;
    pre_addr_exp = m_fpc;
    hs      = im_req_valid && im_req_ready;
    resp_s  = im_resp_valid;
    rdata_s = im_resp_data;
    stall_s = stall;
    reset_s = reset;
    ready_s = im_req_ready;
    npc_s   = npc;
    @(posedge clk);
    #1;
    if (reset_s) begin
      model_reset();
    end else begin
      resp_seen = resp_s && m_pending;
      avail = resp_seen || m_buf_valid || (bad && !m_pending);
      word  = resp_seen ? rdata_s : (m_buf_valid ? m_buf : 32'h0);
      exc   = !resp_seen && !m_buf_valid && bad;
      if (stall_s) begin
        if (resp_seen) begin m_buf_valid = 1'b1; m_buf = rdata_s; end
      end else if (avail) begin
        m_dpc = m_fpc; m_instr = word; m_valid = 1'b1; m_exc = exc;
        m_fpc = npc_s; m_buf_valid = 1'b0;
      end else begin
        m_dpc = m_fpc; m_instr = '0; m_valid = 1'b0; m_exc = 1'b0;
      end
      if (resp_seen) m_pending = 1'b0;
      if (pre_req_exp && ready_s) m_pending = 1'b1;
    end
    if (resp_s) mem_busy = 1'b0;
    if (hs) begin
      mem_busy = 1'b1; mem_addr = pre_addr_dut; mem_cnt = mem_lat;
      req_count[pre_addr_dut] = get_count(pre_addr_dut) + 1;
    end
    if (mem_busy && mem_cnt == 0) begin
      im_resp_valid = 1'b1; im_resp_data = mem_word(mem_addr);
    end else begin
      im_resp_valid = 1'b0; im_resp_data = $urandom;
      if (mem_busy) mem_cnt--;
    end
    drive_npc();
  endtask

  task automatic do_reset();
    reset = 1'b1; stall = 1'b0; im_req_ready = 1'b1; mem_lat = 0;
    redir_from.delete(); redir_to.delete();
    tick(); tick();
    mem_busy = 1'b0; im_resp_valid = 1'b0;
    reset = 1'b0;
    req_count.delete();
    drive_npc();
  endtask

  task automatic test_reset();
    reset = 1'b1; stall = 1'b0; im_req_ready = 1'b1;
    tick();
    n_checks++; if (pre_req_dut !== 1'b0) begin n_fail++; $display("FAIL reset_req_valid: got %b expected 0", pre_req_dut); end
    n_checks++; if (F_PC !== T_RESET) begin n_fail++; $display("FAIL reset_fpc: got %h expected %h", F_PC, T_RESET); end
    n_checks++; if (D_PC !== T_RESET) begin n_fail++; $display("FAIL reset_dpc: got %h expected %h", D_PC, T_RESET); end
    n_checks++; if (D_instr !== 32'h0) begin n_fail++; $display("FAIL reset_instr: got %h expected 0", D_instr); end
    n_checks++; if (D_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", D_valid); end
    n_checks++; if (D_exc_adel !== 1'b0) begin n_fail++; $display("FAIL reset_exc: got %b expected 0", D_exc_adel); end
  endtask

  task automatic test_zero_wait();
    logic [31:0] exp_pc;
    do_reset();
    for (int k = 1; k <= 6; k++) begin
      tick();
      n_checks++; if (pre_req_dut !== (k % 2 == 1)) begin n_fail++; $display("FAIL zw_req k=%0d: got %b expected %b", k, pre_req_dut, (k % 2 == 1)); end
      n_checks++; if (D_valid !== (k % 2 == 0)) begin n_fail++; $display("FAIL zw_valid k=%0d: got %b expected %b", k, D_valid, (k % 2 == 0)); end
      if (k % 2 == 0) begin
        exp_pc = T_RESET + 32'(4 * (k / 2 - 1));
        n_checks++; if (D_PC !== exp_pc) begin n_fail++; $display("FAIL zw_dpc k=%0d: got %h expected %h", k, D_PC, exp_pc); end
        n_checks++; if (D_instr !== mem_word(exp_pc)) begin n_fail++; $display("FAIL zw_instr k=%0d: got %h expected %h", k, D_instr, mem_word(exp_pc)); end
      end else begin
        exp_pc = T_RESET + 32'(4 * ((k - 1) / 2));
        n_checks++; if (pre_addr_dut !== exp_pc) begin n_fail++; $display("FAIL zw_addr k=%0d: got %h expected %h", k, pre_addr_dut, exp_pc); end
        n_checks++; if (D_instr !== 32'h0) begin n_fail++; $display("FAIL zw_bubble k=%0d: got %h expected 0", k, D_instr); end
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    tick(); tick();
    im_req_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_checks++; if (pre_req_dut !== 1'b1 || pre_addr_dut !== 32'h3004) begin n_fail++; $display("FAIL bp_req k=%0d: got %b/%h expected 1/00003004", k, pre_req_dut, pre_addr_dut); end
      n_checks++; if (D_valid !== 1'b0 || D_instr !== 32'h0) begin n_fail++; $display("FAIL bp_bubble k=%0d: got %b/%h expected 0/0", k, D_valid, D_instr); end
      n_checks++; if (F_PC !== 32'h3004) begin n_fail++; $display("FAIL bp_fpc k=%0d: got %h expected 00003004", k, F_PC); end
    end
    im_req_ready = 1'b1;
    tick();
    n_checks++; if (pre_req_dut !== 1'b1 || D_valid !== 1'b0) begin n_fail++; $display("FAIL bp_accept: got req %b valid %b expected 1/0", pre_req_dut, D_valid); end
    tick();
    n_checks++; if (D_PC !== 32'h3004 || D_valid !== 1'b1 || D_instr !== mem_word(32'h3004)) begin n_fail++; $display("FAIL bp_enter: got %h/%b/%h expected 00003004/1/%h", D_PC, D_valid, D_instr, mem_word(32'h3004)); end
  endtask

  task automatic test_stall_buffer();
    do_reset();
    for (int k = 0; k < 5; k++) tick();
    stall = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      n_checks++; if (pre_req_dut !== 1'b0) begin n_fail++; $display("FAIL st_req k=%0d: got %b expected 0", k, pre_req_dut); end
      n_checks++; if (F_PC !== 32'h3008 || D_PC !== 32'h3008 || D_valid !== 1'b0) begin n_fail++; $display("FAIL st_frozen k=%0d: got %h/%h/%b expected 00003008/00003008/0", k, F_PC, D_PC, D_valid); end
    end
    stall = 1'b0;
    tick();
    n_checks++; if (D_PC !== 32'h3008 || D_valid !== 1'b1 || D_instr !== mem_word(32'h3008)) begin n_fail++; $display("FAIL st_release: got %h/%b/%h expected 00003008/1/%h", D_PC, D_valid, D_instr, mem_word(32'h3008)); end
    n_checks++; if (F_PC !== 32'h300C) begin n_fail++; $display("FAIL st_fpc: got %h expected 0000300c", F_PC); end
    tick(); tick();
    n_checks++; if (get_count(32'h3008) != 1) begin n_fail++; $display("FAIL st_refetch: got %0d requests expected 1", get_count(32'h3008)); end
  endtask

  task automatic test_branch();
    logic [31:0] seen [$];
    logic [31:0] exp_seq [6];
    exp_seq = '{32'h3000, 32'h3004, 32'h3008, 32'h300C, 32'h3010, 32'h3040};
    do_reset();
    redir_from.push_back(32'h3010); redir_to.push_back(32'h3040);
    drive_npc();
    for (int k = 0; k < 12; k++) begin
      tick();
      if (D_valid === 1'b1) seen.push_back(D_PC);
    end
    n_checks++; if (seen.size() != 6) begin n_fail++; $display("FAIL br_count: got %0d expected 6", seen.size()); end
    for (int i = 0; i < 6 && i < seen.size(); i++) begin
      n_checks++; if (seen[i] !== exp_seq[i]) begin n_fail++; $display("FAIL br_seq[%0d]: got %h expected %h", i, seen[i], exp_seq[i]); end
    end
  endtask

  task automatic test_bad_addr();
    do_reset();
    redir_from.push_back(32'h3000); redir_to.push_back(32'h3002);
    redir_from.push_back(32'h3002); redir_to.push_back(32'h7000);
    redir_from.push_back(32'h7000); redir_to.push_back(32'h3004);
    drive_npc();
    tick(); tick();
    tick();
    n_checks++; if (pre_req_dut !== 1'b0) begin n_fail++; $display("FAIL bad_misalign_req: got %b expected 0", pre_req_dut); end
    n_checks++; if (D_PC !== 32'h3002 || D_instr !== 32'h0 || D_valid !== 1'b1 || D_exc_adel !== 1'b1) begin n_fail++; $display("FAIL bad_misalign_d: got %h/%h/%b/%b expected 00003002/0/1/1", D_PC, D_instr, D_valid, D_exc_adel); end
    stall = 1'b1;
    tick();
    n_checks++; if (pre_req_dut !== 1'b0 || F_PC !== 32'h7000 || D_PC !== 32'h3002 || D_exc_adel !== 1'b1) begin n_fail++; $display("FAIL bad_stall: got req %b fpc %h dpc %h exc %b", pre_req_dut, F_PC, D_PC, D_exc_adel); end
    stall = 1'b0;
    tick();
    n_checks++; if (pre_req_dut !== 1'b0) begin n_fail++; $display("FAIL bad_range_req: got %b expected 0", pre_req_dut); end
    n_checks++; if (D_PC !== 32'h7000 || D_instr !== 32'h0 || D_valid !== 1'b1 || D_exc_adel !== 1'b1) begin n_fail++; $display("FAIL bad_range_d: got %h/%h/%b/%b expected 00007000/0/1/1", D_PC, D_instr, D_valid, D_exc_adel); end
    tick();
    n_checks++; if (pre_req_dut !== 1'b1 || pre_addr_dut !== 32'h3004) begin n_fail++; $display("FAIL bad_recover: got %b/%h expected 1/00003004", pre_req_dut, pre_addr_dut); end
    n_checks++; if (get_count(32'h3002) + get_count(32'h7000) != 0) begin n_fail++; $display("FAIL bad_sent: got %0d requests expected 0", get_count(32'h3002) + get_count(32'h7000)); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    mem_lat = 1;
    tick();
    reset = 1'b1;
    tick();
    n_checks++; if (F_PC !== T_RESET || D_valid !== 1'b0) begin n_fail++; $display("FAIL rm_reset: got fpc %h valid %b expected 00003000/0", F_PC, D_valid); end
    reset = 1'b0; mem_lat = 0;
    tick();
    n_checks++; if (pre_req_dut !== 1'b1 || pre_addr_dut !== T_RESET) begin n_fail++; $display("FAIL rm_fresh_req: got %b/%h expected 1/00003000", pre_req_dut, pre_addr_dut); end
    n_checks++; if (D_valid !== 1'b0) begin n_fail++; $display("FAIL rm_stale_ignored: got valid %b expected 0", D_valid); end
    tick();
    n_checks++; if (D_PC !== T_RESET || D_valid !== 1'b1 || D_instr !== mem_word(T_RESET)) begin n_fail++; $display("FAIL rm_enter: got %h/%b/%h expected 00003000/1/%h", D_PC, D_valid, D_instr, mem_word(T_RESET)); end
    n_checks++; if (get_count(T_RESET) != 2) begin n_fail++; $display("FAIL rm_req_count: got %0d expected 2", get_count(T_RESET)); end
  endtask

  task automatic test_random();
    int r;
    do_reset();
    for (int c = 0; c < 800; c++) begin
      im_req_ready = ($urandom_range(0, 3) != 0);
      stall        = ($urandom_range(0, 4) == 0);
      mem_lat      = $urandom_range(0, 2);
      reset        = ($urandom_range(0, 199) == 0);
      r = $urandom_range(0, 99);
      if (r < 8)       npc = T_BASE + (32'($urandom_range(0, 32'h0FFF)) << 2);
      else if (r < 10) npc = $urandom;
      else if (r < 12) npc = m_fpc + 32'd2;
      else if (r < 14) npc = T_TOP;
      tick();
      n_checks++; if (pre_req_dut !== pre_req_exp) begin n_fail++; $display("FAIL rnd_req c=%0d: got %b expected %b", c, pre_req_dut, pre_req_exp); end
      if (pre_req_exp) begin
        n_checks++; if (pre_addr_dut !== pre_addr_exp) begin n_fail++; $display("FAIL rnd_addr c=%0d: got %h expected %h", c, pre_addr_dut, pre_addr_exp); end
      end
      n_checks++; if (F_PC !== m_fpc) begin n_fail++; $display("FAIL rnd_fpc c=%0d: got %h expected %h", c, F_PC, m_fpc); end
      n_checks++; if (D_PC !== m_dpc) begin n_fail++; $display("FAIL rnd_dpc c=%0d: got %h expected %h", c, D_PC, m_dpc); end
      n_checks++; if (D_instr !== m_instr) begin n_fail++; $display("FAIL rnd_instr c=%0d: got %h expected %h", c, D_instr, m_instr); end
      n_checks++; if (D_valid !== m_valid || D_exc_adel !== m_exc) begin n_fail++; $display("FAIL rnd_flags c=%0d: got %b/%b expected %b/%b", c, D_valid, D_exc_adel, m_valid, m_exc); end
    end
    reset = 1'b0; stall = 1'b0;
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; npc = '0;
    im_req_ready = 1'b0; im_resp_valid = 1'b0; im_resp_data = '0;
    model_reset();
    test_reset();
    test_zero_wait();
    test_backpressure();
    test_stall_buffer();
    test_branch();
    test_bad_addr();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
